// File: rtl/sym_mapper.sv
// Byte-to-symbol mapper: serialises each input byte into BPSK, QPSK or 16-QAM
// I/Q samples behind a registered valid/ready output stage.
module sym_mapper #(
    parameter int OUT_W      = 16,
    parameter int AMP_PSK    = 23170,
    parameter int AMP_QAM_LO = 10362,
    parameter int AMP_QAM_HI = 31086
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              cfg_mode,
    input  logic                    s_axis_valid,
    output logic                    s_axis_ready,
    input  logic [7:0]              s_axis_data,
    input  logic                    s_axis_last,
    input  logic                    s_axis_sop,
    input  logic                    s_axis_is_parity,
    output logic                    m_axis_valid,
    input  logic                    m_axis_ready,
    output logic signed [OUT_W-1:0] m_axis_i,
    output logic signed [OUT_W-1:0] m_axis_q,
    output logic                    m_axis_last,
    output logic                    m_axis_sop,
    output logic                    m_axis_is_parity,
    output logic [1:0]              m_axis_mode
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [1:0] MODE_BPSK  = 2'd0;
    localparam logic [1:0] MODE_QPSK  = 2'd1;
    localparam logic [1:0] MODE_QAM16 = 2'd2;

    localparam logic signed [OUT_W-1:0] A_PSK = OUT_W'(AMP_PSK);
    localparam logic signed [OUT_W-1:0] A_LO  = OUT_W'(AMP_QAM_LO);
    localparam logic signed [OUT_W-1:0] A_HI  = OUT_W'(AMP_QAM_HI);

    function automatic logic [2:0] last_idx(input logic [1:0] mode);
        case (mode)
            MODE_BPSK:  return 3'd7;
            MODE_QAM16: return 3'd1;
            default:    return 3'd3;
        endcase
    endfunction

    function automatic logic signed [OUT_W-1:0] psk(input logic b);
        return b ? A_PSK : -A_PSK;
    endfunction

    // Sign bit selects polarity, magnitude bit selects inner (1) or outer (0) level.
    function automatic logic signed [OUT_W-1:0] qam(input logic s, input logic m);
        logic signed [OUT_W-1:0] mag;
        mag = m ? A_LO : A_HI;
        return s ? mag : -mag;
    endfunction

    state_t                  state_q;
    logic [2:0]              idx_q;
    logic [7:0]              byte_q;
    logic [1:0]              bmode_q;
    logic                    bsop_q, blast_q, bpar_q;
    logic [1:0]              mode_lat_q;
    logic                    mvalid_q, msop_q, mlast_q, mpar_q;
    logic signed [OUT_W-1:0] mi_q, mq_q;
    logic [1:0]              mmode_q;

    logic                    busy, load, final_sym, accept, emit;
    logic [1:0]              in_mode, sel_mode;
    logic [7:0]              sel_data;
    logic                    sel_sop, sel_last, sel_par;
    logic [2:0]              sel_idx, shamt;
    logic [3:0]              sym_bits;
    logic signed [OUT_W-1:0] i_d, q_d;
    logic                    sop_d, last_d;

    assign busy      = (state_q == SHIFT);
    assign load      = !mvalid_q || m_axis_ready;
    assign final_sym = busy && (idx_q == last_idx(bmode_q));

    assign s_axis_ready = !rst && (!busy || (load && final_sym));
    assign accept       = s_axis_valid && s_axis_ready;
    assign in_mode      = s_axis_sop ? ((cfg_mode == 2'd3) ? MODE_QPSK : cfg_mode) : mode_lat_q;

    // When idle, a freshly accepted byte feeds the output stage directly (1-cycle latency).
    assign sel_data = busy ? byte_q  : s_axis_data;
    assign sel_mode = busy ? bmode_q : in_mode;
    assign sel_sop  = busy ? bsop_q  : s_axis_sop;
    assign sel_last = busy ? blast_q : s_axis_last;
    assign sel_par  = busy ? bpar_q  : s_axis_is_parity;
    assign sel_idx  = busy ? idx_q   : 3'd0;
    assign emit     = load && (busy || accept);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        shamt = {sel_idx[1:0], 1'b0};
        i_d   = '0;
        q_d   = '0;
        case (sel_mode)
            MODE_BPSK:  shamt = sel_idx;
            MODE_QAM16: shamt = {sel_idx[0], 2'b00};
            default:    shamt = {sel_idx[1:0], 1'b0};
        endcase
        sym_bits = 4'((sel_data << shamt) >> 4);
        case (sel_mode)
            MODE_BPSK: i_d = psk(sym_bits[3]);
            MODE_QAM16: begin
                i_d = qam(sym_bits[3], sym_bits[2]);
                q_d = qam(sym_bits[1], sym_bits[0]);
            end
            default: begin
                i_d = psk(sym_bits[3]);
                q_d = psk(sym_bits[2]);
            end
        endcase
    end

    assign sop_d  = (sel_idx == 3'd0) && sel_sop;
    assign last_d = (sel_idx == last_idx(sel_mode)) && sel_last;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            byte_q     <= '0;
            bmode_q    <= MODE_QPSK;
            bsop_q     <= 1'b0;
            blast_q    <= 1'b0;
            bpar_q     <= 1'b0;
            mode_lat_q <= MODE_QPSK;
            mvalid_q   <= 1'b0;
            msop_q     <= 1'b0;
            mlast_q    <= 1'b0;
            mpar_q     <= 1'b0;
            mi_q       <= '0;
            mq_q       <= '0;
            mmode_q    <= MODE_QPSK;
        end else begin
            if (accept && s_axis_sop)
                mode_lat_q <= in_mode;

            if (accept) begin
                byte_q  <= s_axis_data;
                bmode_q <= in_mode;
                bsop_q  <= s_axis_sop;
                blast_q <= s_axis_last;
                bpar_q  <= s_axis_is_parity;
            end

            if (load) begin
                mvalid_q <= emit;
                if (emit) begin
                    mi_q    <= i_d;
                    mq_q    <= q_d;
                    msop_q  <= sop_d;
                    mlast_q <= last_d;
                    mpar_q  <= sel_par;
                    mmode_q <= sel_mode;
                end
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= SHIFT;
                        idx_q   <= load ? 3'd1 : 3'd0;
                    end
                end
                SHIFT: begin
                    if (load) begin
                        if (final_sym) begin
                            idx_q   <= '0;
                            state_q <= accept ? SHIFT : IDLE;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_axis_valid     = mvalid_q;
    assign m_axis_i         = mi_q;
    assign m_axis_q         = mq_q;
    assign m_axis_sop       = msop_q;
    assign m_axis_last      = mlast_q;
    assign m_axis_is_parity = mpar_q;
    assign m_axis_mode      = mmode_q;

endmodule
